// File: rtl/cubehash_round_sched.sv
// Sequencing controller for the iterative CubeHash state/round datapath.
// Define CUBEHASH_ABORT_EN to add an `abort` input that returns the controller to IDLE.
module cubehash_round_sched #(
    parameter int ROUNDS   = 16,
    parameter int FIN_MULT = 10,
    parameter int CNT_W    = 8
) (
    input  logic clk,
    input  logic rst_p,
`ifdef CUBEHASH_ABORT_EN
    input  logic abort,
`endif
    input  logic start,
    input  logic msg_valid,
    input  logic msg_last,
    output logic msg_ready,
    output logic sel_iv,
    output logic absorb,
    output logic round_en,
    output logic fin_xor,
    output logic out_en,
    output logic busy,
    output logic err
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_BLK,
        ROUND,
        FIN_X,
        FIN_ROUND,
        DONE
    } state_t;

    localparam logic [CNT_W-1:0] ROUND_LOAD = CNT_W'(ROUNDS - 1);
    localparam logic [CNT_W-1:0] FIN_LOAD   = CNT_W'(FIN_MULT * ROUNDS - 1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             first_q;
    logic             last_q;
    logic             ready_q;
    logic             round_q;
    logic             fin_q;
    logic             out_q;
    logic             busy_q;
    logic             abort_hit;
    logic             xfer;

`ifdef CUBEHASH_ABORT_EN
    assign abort_hit = abort && (state != IDLE);
`else
    assign abort_hit = 1'b0;
`endif

    // Strobes are registered from the next state; abort masks them in its own cycle.
    assign msg_ready = ready_q && !abort_hit;
    assign round_en  = round_q && !abort_hit;
    assign fin_xor   = fin_q && !abort_hit;
    assign out_en    = out_q && !abort_hit;
    assign busy      = busy_q;
    assign xfer      = msg_valid && msg_ready;
    assign absorb    = xfer;
    assign sel_iv    = xfer && first_q;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (start) state_nxt = WAIT_BLK;
            WAIT_BLK:  if (xfer) state_nxt = ROUND;
            ROUND:     if (cnt == '0) state_nxt = last_q ? FIN_X : WAIT_BLK;
            FIN_X:     state_nxt = FIN_ROUND;
            FIN_ROUND: if (cnt == '0) state_nxt = DONE;
            DONE:      state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
        if (abort_hit) begin
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_p) begin
            state   <= IDLE;
            cnt     <= '0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
            ready_q <= 1'b0;
            round_q <= 1'b0;
            fin_q   <= 1'b0;
            out_q   <= 1'b0;
            busy_q  <= 1'b0;
            err     <= 1'b0;
        end else begin
            state   <= state_nxt;
            ready_q <= (state_nxt == WAIT_BLK);
            round_q <= (state_nxt == ROUND) || (state_nxt == FIN_ROUND);
            fin_q   <= (state_nxt == FIN_X);
            out_q   <= (state_nxt == DONE);
            busy_q  <= (state_nxt != IDLE);

            if (!abort_hit) begin
                case (state)
                    IDLE: begin
                        if (start) first_q <= 1'b1;
                    end
                    WAIT_BLK: begin
                        if (xfer) begin
                            first_q <= 1'b0;
                            cnt     <= ROUND_LOAD;
                            last_q  <= msg_last;
                        end
                    end
                    ROUND, FIN_ROUND: begin
                        if (cnt != '0) cnt <= cnt - CNT_W'(1);
                    end
                    FIN_X: begin
                        cnt <= FIN_LOAD;
                    end
                    default: begin
                    end
                endcase

                // Only an accepted start clears the sticky error; busy_q mirrors state != IDLE.
                if (state == IDLE && start) begin
                    err <= 1'b0;
                end else if (busy_q && ((msg_valid && !msg_ready) || start)) begin
                    err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_cubehash_round_sched.sv
// Directed testbench for cubehash_round_sched at default parameters (178-cycle last-block latency).
module tb_cubehash_round_sched;

    logic clk = 1'b0;
    logic rst_p = 1'b1;
    logic start = 1'b0;
    logic msg_valid = 1'b0;
    logic msg_last = 1'b0;
`ifdef CUBEHASH_ABORT_EN
    logic abort = 1'b0;
`endif
    logic msg_ready, sel_iv, absorb, round_en, fin_xor, out_en, busy, err;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    cubehash_round_sched dut (
        .clk       (clk),
        .rst_p     (rst_p),
`ifdef CUBEHASH_ABORT_EN
        .abort     (abort),
`endif
        .start     (start),
        .msg_valid (msg_valid),
        .msg_last  (msg_last),
        .msg_ready (msg_ready),
        .sel_iv    (sel_iv),
        .absorb    (absorb),
        .round_en  (round_en),
        .fin_xor   (fin_xor),
        .out_en    (out_en),
        .busy      (busy),
        .err       (err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept a start in IDLE, then idle in WAIT_BLK for two cycles.
    task automatic start_msg();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
    endtask

    // Present a block in WAIT_BLK; the next clock edge transfers it.
    task automatic send_block(input logic last, output logic a, output logic s, output logic r);
        msg_valid = 1'b1;
        msg_last  = last;
        #1;
        a = absorb;
        s = sel_iv;
        r = msg_ready;
    endtask

    // Runs cycles after a transfer; n=1 is the first cycle after the transfer edge.
    // kind: 0 none, 1 msg_valid pulse, 2 start pulse, 4 abort pulse, applied in cycle inj_at.
    task automatic run_msg(input int kind, input int inj_at, input int budget,
                           output int out_at, output int rounds, output int fins);
        out_at = -1;
        rounds = 0;
        fins   = 0;
        for (int n = 1; n <= budget; n++) begin
            tick();
            msg_valid = (kind == 1 && n == inj_at);
            msg_last  = 1'b0;
            start     = (kind == 2 && n == inj_at);
`ifdef CUBEHASH_ABORT_EN
            abort     = (kind == 4 && n == inj_at);
`endif
            #1;
            if (round_en) rounds++;
            if (fin_xor) fins++;
            if (out_en) begin
                out_at = n;
                break;
            end
        end
        tick();
        msg_valid = 1'b0;
        start     = 1'b0;
`ifdef CUBEHASH_ABORT_EN
        abort     = 1'b0;
`endif
        #1;
    endtask

    task automatic test_reset();
        logic [7:0] outs;
        rst_p = 1'b1;
        tick();
        tick();
        rst_p = 1'b0;
        outs = {msg_ready, sel_iv, absorb, round_en, fin_xor, out_en, busy, err};
        tests++;
        if (outs !== 8'h00) begin
            fails++;
            $display("[TB] FAIL reset_outputs: got %b expected 00000000", outs);
        end
        msg_valid = 1'b1;
        tick();
        msg_valid = 1'b0;
        tick();
        tests++;
        if ({busy, err, absorb} !== 3'b000) begin
            fails++;
            $display("[TB] FAIL idle_msg_valid: busy/err/absorb got %b expected 000", {busy, err, absorb});
        end
    endtask

    task automatic test_single_block();
        logic a, s, r;
        int out_at, rounds, fins;
        start_msg();
        send_block(1'b1, a, s, r);
        tests++;
        if ({a, s, r} !== 3'b111) begin
            fails++;
            $display("[TB] FAIL single_absorb: absorb/sel_iv/ready got %b expected 111", {a, s, r});
        end
        run_msg(0, 0, 250, out_at, rounds, fins);
        tests++;
        if (out_at !== 178) begin
            fails++;
            $display("[TB] FAIL single_latency: out_en at %0d expected 178", out_at);
        end
        tests++;
        if (rounds !== 176 || fins !== 1) begin
            fails++;
            $display("[TB] FAIL single_counts: rounds %0d fin %0d expected 176 1", rounds, fins);
        end
        tests++;
        if ({busy, out_en, err} !== 3'b000) begin
            fails++;
            $display("[TB] FAIL single_after: busy/out_en/err got %b expected 000", {busy, out_en, err});
        end
    endtask

    task automatic test_two_blocks();
        logic a, s, r;
        int out_at, rounds, fins, first_rounds, ready_seen;
        start_msg();
        send_block(1'b0, a, s, r);
        first_rounds = 0;
        ready_seen   = 0;
        for (int n = 1; n <= 16; n++) begin
            tick();
            msg_valid = 1'b0;
            #1;
            if (round_en) first_rounds++;
            if (msg_ready) ready_seen++;
        end
        tests++;
        if (first_rounds !== 16 || ready_seen !== 0) begin
            fails++;
            $display("[TB] FAIL two_first_rounds: rounds %0d ready_cycles %0d expected 16 0", first_rounds, ready_seen);
        end
        tick();
        tests++;
        if (msg_ready !== 1'b1) begin
            fails++;
            $display("[TB] FAIL two_ready_again: msg_ready got %b expected 1", msg_ready);
        end
        send_block(1'b1, a, s, r);
        tests++;
        if ({a, s} !== 2'b10) begin
            fails++;
            $display("[TB] FAIL two_second_absorb: absorb/sel_iv got %b expected 10", {a, s});
        end
        run_msg(0, 0, 250, out_at, rounds, fins);
        tests++;
        if (out_at !== 178 || first_rounds + rounds !== 192) begin
            fails++;
            $display("[TB] FAIL two_total: out_at %0d total rounds %0d expected 178 192", out_at, first_rounds + rounds);
        end
    endtask

    task automatic test_protocol_error();
        logic a, s, r;
        int out_at, rounds, fins;
        start_msg();
        send_block(1'b1, a, s, r);
        run_msg(1, 5, 250, out_at, rounds, fins);
        tests++;
        if (err !== 1'b1) begin
            fails++;
            $display("[TB] FAIL proto_err_set: err got %b expected 1", err);
        end
        tests++;
        if (out_at !== 178 || rounds !== 176) begin
            fails++;
            $display("[TB] FAIL proto_sequence: out_at %0d rounds %0d expected 178 176", out_at, rounds);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        tests++;
        if (err !== 1'b0 || busy !== 1'b1) begin
            fails++;
            $display("[TB] FAIL proto_err_clear: err/busy got %b%b expected 01", err, busy);
        end
    endtask

    task automatic test_start_busy();
        logic a, s, r;
        int out_at, rounds, fins;
        // The previous test leaves the controller in WAIT_BLK with err cleared.
        tick();
        send_block(1'b1, a, s, r);
        run_msg(2, 50, 250, out_at, rounds, fins);
        tests++;
        if (err !== 1'b1 || out_at !== 178) begin
            fails++;
            $display("[TB] FAIL start_busy_fin: err %b out_at %0d expected 1 178", err, out_at);
        end
        start_msg();
        tests++;
        if (err !== 1'b0) begin
            fails++;
            $display("[TB] FAIL start_busy_clear: err got %b expected 0", err);
        end
        send_block(1'b1, a, s, r);
        run_msg(2, 178, 250, out_at, rounds, fins);
        tests++;
        if (out_at !== 178 || err !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("[TB] FAIL start_in_done: out_at %0d err %b busy %b expected 178 1 0", out_at, err, busy);
        end
    endtask

    task automatic test_reset_mid_round();
        logic a, s, r;
        logic [7:0] outs;
        int late;
        start_msg();
        send_block(1'b1, a, s, r);
        for (int n = 1; n <= 7; n++) begin
            tick();
            msg_valid = 1'b0;
            msg_last  = 1'b0;
        end
        rst_p = 1'b1;
        tick();
        rst_p = 1'b0;
        outs = {msg_ready, sel_iv, absorb, round_en, fin_xor, out_en, busy, err};
        tests++;
        if (outs !== 8'h00) begin
            fails++;
            $display("[TB] FAIL reset_mid_outputs: got %b expected 00000000", outs);
        end
        late = 0;
        for (int n = 0; n < 200; n++) begin
            tick();
            if (out_en || busy || round_en) late++;
        end
        tests++;
        if (late !== 0) begin
            fails++;
            $display("[TB] FAIL reset_mid_quiet: active cycles %0d expected 0", late);
        end
    endtask

`ifdef CUBEHASH_ABORT_EN
    task automatic test_abort();
        logic a, s, r;
        int out_at, rounds, fins;
        start_msg();
        send_block(1'b1, a, s, r);
        run_msg(4, 60, 250, out_at, rounds, fins);
        tests++;
        if (out_at !== -1 || rounds !== 58 || busy !== 1'b0) begin
            fails++;
            $display("[TB] FAIL abort_fin: out_at %0d rounds %0d busy %b expected -1 58 0", out_at, rounds, busy);
        end
        start_msg();
        send_block(1'b1, a, s, r);
        run_msg(0, 0, 250, out_at, rounds, fins);
        tests++;
        if (out_at !== 178 || rounds !== 176) begin
            fails++;
            $display("[TB] FAIL abort_restart: out_at %0d rounds %0d expected 178 176", out_at, rounds);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_block();
        test_two_blocks();
        test_protocol_error();
        test_start_busy();
        test_reset_mid_round();
`ifdef CUBEHASH_ABORT_EN
        test_abort();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cubehash_round_sched.md
Name: cubehash_round_sched

Overview:
- Sequencing controller for the iterative CubeHash datapath: a 1024-bit state register feeding one combinational round per clock.
- Decides each cycle whether the state register loads the IV, absorbs a 256-bit message block, runs a round, applies the finalization XOR, or holds.
- Counts rounds per block and for finalization, and emits a one-cycle hash-valid pulse.
- Sits between the byte-to-256 packer (block handshake) and the state/round datapath (mux selects and enables).

Parameters:
- ROUNDS, 16, rounds per absorbed block (CubeHash r).
- FIN_MULT, 10, finalization rounds = FIN_MULT*ROUNDS.
- CNT_W, 8, round counter width; must hold FIN_MULT*ROUNDS-1.

Ports:
- clk  input  1  clock.
- rst_p  input  1  synchronous active-high reset.
- start  input  1  begin a new message; accepted in IDLE only.
- msg_valid  input  1  packed 256-bit block available (packer done).
- msg_last  input  1  qualifies msg_valid; block is the final (already padded) block.
- msg_ready  output  1  controller accepts a block this cycle.
- sel_iv  output  1  datapath absorbs into IV instead of current state.
- absorb  output  1  state <= (sel_iv ? IV : state) ^ {msg, 768'b0}.
- round_en  output  1  state <= round(state).
- fin_xor  output  1  state <= state with bit 0 inverted.
- out_en  output  1  one-cycle pulse: state holds the final hash.
- busy  output  1  high in every state except IDLE.
- err  output  1  sticky protocol error flag.

Behaviour:
- Interface: one clock `clk`; synchronous, active-high reset `rst_p`.
- Reset: state IDLE, counter 0, first-block flag 0. All outputs 0, err 0. Applies mid-operation: aborts the current message and returns to IDLE next cycle.
- Handshake: a block is transferred when msg_valid && msg_ready. msg_ready=1 only in WAIT_BLK.
- At most one of absorb/round_en/fin_xor is high in any cycle. The state register holds whenever all three are 0.
- FSM states:
  - IDLE: start=1 -> WAIT_BLK; set first-block flag.
  - WAIT_BLK: msg_ready=1. On transfer, in the same cycle: absorb=1, sel_iv=first flag. Then clear first flag, load counter=ROUNDS-1, latch msg_last, go to ROUND.
  - ROUND: round_en=1 each cycle; counter decrements. At counter=0: latched last=0 -> WAIT_BLK; latched last=1 -> FIN_X.
  - FIN_X: fin_xor=1 for 1 cycle; counter=FIN_MULT*ROUNDS-1; -> FIN_ROUND.
  - FIN_ROUND: round_en=1 each cycle; at counter=0 -> DONE.
  - DONE: out_en=1 for 1 cycle; -> IDLE.
- Latency:
  - Per block: 1 absorb cycle + ROUNDS round cycles.
  - Last block transfer to out_en: 1 + ROUNDS + 1 + FIN_MULT*ROUNDS cycles (178 at defaults).
- Errors (sticky until next accepted start or reset; no effect on sequencing):
  - msg_valid=1 while msg_ready=0 and busy=1 (block dropped).
  - start=1 while busy=1 (ignored).
- msg_valid in IDLE: ignored, no error.
- start and out_en in the same cycle (DONE): start ignored and flagged as error.
- Counter wraps never occur; it is reloaded before every use.

Optional Feature:
- CUBEHASH_ABORT_EN defined:
  - Adds input `abort` (1 bit).
  - abort=1 in any non-IDLE state -> IDLE next cycle; all strobes 0 that cycle; err unchanged; no out_en.
  - abort has priority over start and transfers. In IDLE it has no effect.
- Undefined: port absent; sequencing as above.

Test Plan:
- Single block: reset, start, msg_valid+msg_last 3 cycles later -> 1 absorb cycle with sel_iv=1, 16 round_en, 1 fin_xor, 160 round_en; out_en exactly 178 cycles after transfer; busy falls with out_en; err=0.
- Two blocks: second block transfers with sel_iv=0 only after 16 rounds. msg_ready=0 throughout ROUND. Total round_en count = 192.
- Protocol error: msg_valid pulsed during ROUND -> err=1, round count unchanged. Next start in IDLE clears err.
- Start while busy: start asserted during FIN_ROUND -> err=1; out_en still at the nominal cycle.
- Reset mid-round: rst_p for 1 cycle during round 7 of a block -> next cycle IDLE, all outputs 0, no out_en afterwards.
- CUBEHASH_ABORT_EN: abort during FIN_ROUND -> IDLE next cycle, no out_en. New start then completes normally in 178 cycles.
